cmd_responder: RTL

Command-interface responder inside LogicCaptureTop. It is the capture side of the hub command handshake. It detects command strobes from the hub and decodes the function code. It latches configuration from the regIn bytes, pulses start/abort/reset into the capture engine, and fetches trace data, trace size and trigger sample into the regOut bytes. It returns ack/idle/error in `status` and completes each transaction only on the hub's CMD_ACK.

---
 rtl/cmd_responder.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cmd_responder.sv
// Hub command responder: decodes strobed function codes, drives engine pulses/config, fetches read data into regOut.
// Latency: strobe edge T -> EXEC at T+1, ack from T+2; trace reads add the traceRdValid wait (bounded by RD_TIMEOUT).
// Backpressure: one transaction in flight; new strobes are ignored until the hub's ACK strobe closes the current one.
module cmd_responder #(
    parameter int RD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  command,
    input  logic        commandStrobe,
    input  logic [7:0]  regIn0,
    input  logic [7:0]  regIn1,
    input  logic [7:0]  regIn2,
    input  logic [7:0]  regIn3,
    input  logic [7:0]  regIn4,
    input  logic [7:0]  regIn5,
    input  logic [7:0]  regIn6,
    input  logic [7:0]  regIn7,
    output logic [7:0]  regOut0,
    output logic [7:0]  regOut1,
    output logic [7:0]  regOut2,
    output logic [7:0]  regOut3,
    output logic [7:0]  regOut4,
    output logic [7:0]  regOut5,
    output logic [7:0]  regOut6,
    output logic [7:0]  regOut7,
    output logic [7:0]  status,
    input  logic        captureBusy,
    input  logic        triggered,
    output logic        startPulse,
    output logic        abortPulse,
    output logic        softReset,
    output logic        traceRdReq,
    input  logic        traceRdValid,
    input  logic [63:0] traceRdData,
    input  logic [31:0] traceSize,
    input  logic [63:0] triggerSample,
    output logic [31:0] preTriggerCount,
    output logic [31:0] totalSampleCount,
    output logic [15:0] desiredPattern,
    output logic [15:0] activeChannels,
    output logic [15:0] dontCare,
    output logic [7:0]  edgeTriggerChannel,
    output logic        edgeTriggerType,
    output logic        edgeTriggerEnable,
    output logic        patternTriggerEnable
);

    localparam logic [7:0] CMD_NOP       = 8'h00;
    localparam logic [7:0] CMD_START     = 8'h01;
    localparam logic [7:0] CMD_ABORT     = 8'h02;
    localparam logic [7:0] CMD_TRIG_CFG  = 8'h03;
    localparam logic [7:0] CMD_BUF_CFG   = 8'h04;
    localparam logic [7:0] CMD_RD_DATA   = 8'h05;
    localparam logic [7:0] CMD_RD_SIZE   = 8'h06;
    localparam logic [7:0] CMD_RD_SAMPLE = 8'h07;
    localparam logic [7:0] CMD_ACK       = 8'h08;
    localparam logic [7:0] CMD_RESET     = 8'h09;

    localparam int TW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RD_WAIT,
        S_ACK_WAIT
    } state_t;

    state_t        state_q;
    logic          strobe_prev_q;
    logic          busy_prev_q;
    logic [7:0]    cmd_q;
    logic [63:0]   regs_q;
    logic [63:0]   regout_q;
    logic          err_q;
    logic          pending_q;
    logic          start_q;
    logic          abort_q;
    logic          sreset_q;
    logic          rdreq_q;
    logic [7:0]    status_q;
    logic [TW-1:0] tmo_q;
    logic [31:0]   total_q;
    logic [31:0]   pre_q;
    logic [15:0]   pattern_q;
    logic [15:0]   active_q;
    logic [15:0]   dc_q;
    logic [7:0]    chan_q;
    logic          etype_q;
    logic          een_q;
    logic          pen_q;

    logic strobe_rise;
    logic busy_rise;
    logic engine_busy;

    assign strobe_rise = commandStrobe & ~strobe_prev_q;
    assign busy_rise   = captureBusy & ~busy_prev_q;
    // Engine counts as busy from START until it reports captureBusy itself.
    assign engine_busy = captureBusy | pending_q;

    // Command FSM with registered pulses, config, response bytes and status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            strobe_prev_q <= 1'b0;
            busy_prev_q   <= 1'b0;
            cmd_q         <= 8'h00;
            regs_q        <= 64'h0;
            regout_q      <= 64'h0;
            err_q         <= 1'b0;
            pending_q     <= 1'b0;
            start_q       <= 1'b0;
            abort_q       <= 1'b0;
            sreset_q      <= 1'b0;
            rdreq_q       <= 1'b0;
            status_q      <= 8'h01;
            tmo_q         <= '0;
            total_q       <= 32'h0;
            pre_q         <= 32'h0;
            pattern_q     <= 16'h0;
            active_q      <= 16'h0;
            dc_q          <= 16'h0;
            chan_q        <= 8'h00;
            etype_q       <= 1'b0;
            een_q         <= 1'b0;
            pen_q         <= 1'b0;
        end else begin
            strobe_prev_q <= commandStrobe;
            busy_prev_q   <= captureBusy;
            start_q       <= 1'b0;
            abort_q       <= 1'b0;
            sreset_q      <= 1'b0;
            rdreq_q       <= 1'b0;
            status_q      <= {3'b000, err_q, (state_q == S_ACK_WAIT), triggered,
                              captureBusy, ~captureBusy & ~pending_q};
            if (busy_rise) begin
                pending_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (strobe_rise && (command != CMD_ACK)) begin
                        cmd_q   <= command;
                        regs_q  <= {regIn7, regIn6, regIn5, regIn4,
                                    regIn3, regIn2, regIn1, regIn0};
                        err_q   <= 1'b0;
                        state_q <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    state_q <= S_ACK_WAIT;
                    case (cmd_q)
                        CMD_NOP: begin
                        end
                        CMD_START: begin
                            if (engine_busy) begin
                                err_q <= 1'b1;
                            end else begin
                                start_q   <= 1'b1;
                                pending_q <= 1'b1;
                            end
                        end
                        CMD_ABORT: begin
                            abort_q   <= 1'b1;
                            pending_q <= 1'b0;
                        end
                        CMD_TRIG_CFG: begin
                            if (engine_busy) begin
                                err_q <= 1'b1;
                            end else begin
                                pattern_q <= regs_q[15:0];
                                active_q  <= regs_q[31:16];
                                dc_q      <= regs_q[47:32];
                                chan_q    <= regs_q[55:48];
                                etype_q   <= regs_q[58];
                                een_q     <= regs_q[57];
                                pen_q     <= regs_q[56];
                            end
                        end
                        CMD_BUF_CFG: begin
                            if (engine_busy) begin
                                err_q <= 1'b1;
                            end else begin
                                total_q <= regs_q[31:0];
                                pre_q   <= regs_q[63:32];
                            end
                        end
                        CMD_RD_DATA: begin
                            rdreq_q <= 1'b1;
                            tmo_q   <= '0;
                            state_q <= S_RD_WAIT;
                        end
                        CMD_RD_SIZE: begin
                            regout_q <= {32'h0, traceSize};
                        end
                        CMD_RD_SAMPLE: begin
                            regout_q <= triggerSample;
                        end
                        CMD_RESET: begin
                            sreset_q  <= 1'b1;
                            pending_q <= 1'b0;
                            regout_q  <= 64'h0;
                            total_q   <= 32'h0;
                            pre_q     <= 32'h0;
                            pattern_q <= 16'h0;
                            active_q  <= 16'h0;
                            dc_q      <= 16'h0;
                            chan_q    <= 8'h00;
                            etype_q   <= 1'b0;
                            een_q     <= 1'b0;
                            pen_q     <= 1'b0;
                        end
                        default: begin
                            // Unknown codes are flagged but still acknowledged.
                            if (cmd_q > CMD_RESET) begin
                                err_q <= 1'b1;
                            end
                        end
                    endcase
                end

                S_RD_WAIT: begin
                    if (traceRdValid) begin
                        regout_q <= traceRdData;
                        state_q  <= S_ACK_WAIT;
                    end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
                        regout_q <= 64'h0;
                        err_q    <= 1'b1;
                        state_q  <= S_ACK_WAIT;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end

                S_ACK_WAIT: begin
                    if (strobe_rise && (command == CMD_ACK)) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign regOut0 = regout_q[7:0];
    assign regOut1 = regout_q[15:8];
    assign regOut2 = regout_q[23:16];
    assign regOut3 = regout_q[31:24];
    assign regOut4 = regout_q[39:32];
    assign regOut5 = regout_q[47:40];
    assign regOut6 = regout_q[55:48];
    assign regOut7 = regout_q[63:56];

    assign status               = status_q;
    assign startPulse           = start_q;
    assign abortPulse           = abort_q;
    assign softReset            = sreset_q;
    assign traceRdReq           = rdreq_q;
    assign preTriggerCount      = pre_q;
    assign totalSampleCount     = total_q;
    assign desiredPattern       = pattern_q;
    assign activeChannels       = active_q;
    assign dontCare             = dc_q;
    assign edgeTriggerChannel   = chan_q;
    assign edgeTriggerType      = etype_q;
    assign edgeTriggerEnable    = een_q;
    assign patternTriggerEnable = pen_q;

endmodule
